fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per frame payload.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port fifo_data_in  input  DATA_WIDTH: head word of the upstream FIFO, valid whenever fifo_empty is 0.
REQ-007 SHALL have port fifo_empty  input  1: upstream FIFO empty flag.
REQ-008 SHALL have port fifo_read_ins  output  1: pop strobe to the FIFO, consumed on its rising edge.
REQ-009 SHALL have port enable  input  1: permits the start of new frames.
REQ-010 SHALL have port tx  output  1: serial line, idle high.
REQ-011 SHALL have port busy  output  1: high from the pop cycle through the last stop-bit cycle.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is present only per REQ-026.
REQ-013 In IDLE, when enable=1 and fifo_empty=0, SHALL latch fifo_data_in into the shift register, drive fifo_read_ins=1 for exactly one cycle, and enter START.
REQ-014 fifo_read_ins SHALL be registered, SHALL never be high for two consecutive cycles, and SHALL pulse only once per frame.
REQ-015 START SHALL drive tx=0 for CLKS_PER_BIT cycles, beginning the cycle after the pop.
REQ-016 DATA SHALL shift out DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles; the bit index counter SHALL be $clog2(DATA_WIDTH+1) bits wide.
REQ-017 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 The baud counter SHALL reload to 0 on every bit boundary and SHALL be $clog2(CLKS_PER_BIT) bits wide, with no drift across frames.
REQ-019 Back-to-back frames: when the FIFO is non-empty after STOP, there SHALL be exactly one IDLE cycle (tx=1) before the next pop.
REQ-020 enable=0 SHALL only block the transition out of IDLE; an in-progress frame SHALL complete unchanged.
REQ-021 fifo_empty and fifo_data_in SHALL be ignored outside IDLE, including when the FIFO is written mid-frame.
REQ-022 tx SHALL be driven from a flop (glitch-free), with tx=1 in IDLE.

Reset
REQ-023 While rst_n=0 at a clk edge: state=IDLE, tx=1, fifo_read_ins=0, busy=0, and the baud counter, bit counter and shift register SHALL be cleared.
REQ-024 Reset mid-frame SHALL abort the frame on the next edge (tx=1); the popped word SHALL be lost and SHALL NOT be re-popped.
REQ-025 The first pop after reset release SHALL occur no earlier than the first edge with rst_n=1.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, SHALL insert a PARITY state between DATA and STOP driving the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles; without the macro, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Verification (CLKS_PER_BIT=4, STOP_BITS=1, DATA_WIDTH=8)
REQ-027 FIFO holds 0xA5 and enable=1 -> one pop pulse, then tx bits 0,1,0,1,0,0,1,0,1,1, each 4 clk; busy high for 41 cycles (pop cycle plus 40 bit cycles); no parity variant.
REQ-028 Same stimulus with UART_TX_PARITY_EN -> parity bit 0 inserted before stop; frame is 44 cycles.
REQ-029 FIFO holds 0x00, 0xFF -> two frames separated by exactly one idle-high cycle; two pops total; FIFO empty afterwards.
REQ-030 enable=0 with FIFO non-empty -> no pop and tx=1 for 100 cycles; enable dropped mid-frame -> frame completes and no further pop occurs.
REQ-031 rst_n=0 for one cycle during DATA bit 3 -> tx=1 and busy=0 on the next edge; next frame carries the following FIFO word.
REQ-032 fifo_empty=1 throughout -> fifo_read_ins never asserts; tx=1 and busy=0 constant.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops payload words from an upstream FIFO and serialises them LSB first.
// Optional even-parity bit between data and stop bits is enabled with UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty,
  output logic                  fifo_read_ins,
  input  logic                  enable,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                r_state, w_state_next;
  logic [BaudW-1:0]      r_baud, w_baud_next;
  logic [BitW-1:0]       r_bit_idx, w_bit_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                  r_tx, w_tx_next;
  logic                  r_read, w_read_next;
  logic                  r_busy, w_busy_next;
  logic                  w_baud_done;

`ifdef UART_TX_PARITY_EN
  logic                  r_parity, w_parity_next;
`endif

  assign w_baud_done   = (r_baud == BaudLast);
  assign fifo_read_ins = r_read;
  assign tx            = r_tx;
  assign busy          = r_busy;

  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit_idx;
    w_shift_next  = r_shift;
    w_tx_next     = r_tx;
    w_read_next   = 1'b0;
    w_busy_next   = r_busy;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    unique case (r_state)
      StIdle: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        if (enable && !fifo_empty) begin
          w_state_next  = StStart;
          w_shift_next  = fifo_data_in;
          w_read_next   = 1'b1;
          w_busy_next   = 1'b1;
          w_baud_next   = '0;
          w_bit_next    = '0;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^fifo_data_in;
`endif
        end
      end
      StStart: begin
        // The pop cycle (r_read high) keeps tx idle; the start bit begins on the next edge.
        if (r_read) begin
          w_tx_next = 1'b0;
        end else if (w_baud_done) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = StData;
          w_tx_next    = r_shift[0];
          w_shift_next = r_shift >> 1;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      StData: begin
        if (w_baud_done) begin
          w_baud_next = '0;
          if (r_bit_idx == DataLast) begin
            w_bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = StParity;
            w_tx_next    = r_parity;
`else
            w_state_next = StStop;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next   = r_bit_idx + 1'b1;
            w_tx_next    = r_shift[0];
            w_shift_next = r_shift >> 1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_baud_done) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = StStop;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
`endif
      StStop: begin
        w_tx_next = 1'b1;
        if (w_baud_done) begin
          w_baud_next = '0;
          if (r_bit_idx == StopLast) begin
            w_bit_next   = '0;
            w_state_next = StIdle;
            w_busy_next  = 1'b0;
          end else begin
            w_bit_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_read    <= w_read_next;
      r_busy    <= w_busy_next;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx with a FIFO model and a bit-level frame reference.
// Honours UART_TX_PARITY_EN when the DUT is built with it.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = 1 + DW + PAR + SB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_empty;
  logic          fifo_read_ins;
  logic          enable;
  logic          tx;
  logic          busy;

  // FIFO model: stim/wr_ptr written only by the stimulus process, rd_ptr only by the pop process.
  logic [DW-1:0] stim [64];
  logic [5:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;
  int            pop_cnt = 0;
  int            dbl_cnt = 0;
  int            empty_pop_cnt = 0;
  logic          rd_prev = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_data_in = stim[rd_ptr];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_data_in (fifo_data_in),
    .fifo_empty   (fifo_empty),
    .fifo_read_ins(fifo_read_ins),
    .enable       (enable),
    .tx           (tx),
    .busy         (busy)
  );

  always @(posedge clk) begin
    if (fifo_read_ins) begin
      if (fifo_empty) empty_pop_cnt <= empty_pop_cnt + 1;
      else begin
        rd_ptr  <= rd_ptr + 6'd1;
        pop_cnt <= pop_cnt + 1;
      end
    end
    if (fifo_read_ins && rd_prev) dbl_cnt <= dbl_cnt + 1;
    rd_prev <= fifo_read_ins;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] v);
    stim[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // Line level of serial bit k of a frame carrying d.
  function automatic logic exp_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    if (PAR == 1 && k == DW + 1) return ^d;
    return 1'b1;
  endfunction

  // Waits for the pop, then checks every line cycle of the frame and the idle cycle after it.
  task automatic run_frame(input logic [DW-1:0] data, input int drop_at, input int rst_at,
                           input int push_at, input logic [DW-1:0] push_val, output int waited);
    waited = 0;
    while (fifo_read_ins !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    if (fifo_read_ins !== 1'b1) begin
      check_eq("pop_wait", 32'(fifo_read_ins), 32'd1);
      return;
    end
    check_eq("pop_busy", 32'(busy), 32'd1);
    check_eq("pop_tx", 32'(tx), 32'd1);
    for (int c = 0; c < FRAME_BITS * CPB; c++) begin
      step();
      if (c == drop_at) enable = 1'b0;
      if (c == push_at) push(push_val);
      check_eq("frame_tx", 32'(tx), 32'(exp_bit(data, c / CPB)));
      check_eq("frame_busy", 32'(busy), 32'd1);
      check_eq("frame_rd", 32'(fifo_read_ins), 32'd0);
      if (c == rst_at) begin
        rst_n = 1'b0;
        step();
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd", 32'(fifo_read_ins), 32'd0);
        rst_n = 1'b1;
        return;
      end
    end
    step();
    check_eq("idle_tx", 32'(tx), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    int viol;
    logic [DW-1:0] cur;
    logic [DW-1:0] nxt;

    rst_n  = 1'b0;
    enable = 1'b0;
    step();
    step();
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_rd", 32'(fifo_read_ins), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    step();

    // Single frame 0xA5.
    push(8'hA5);
    run_frame(8'hA5, -1, -1, -1, '0, w);
    check_eq("a5_wait", 32'(w), 32'd1);
    check_eq("a5_pops", 32'(pop_cnt), 32'd1);

    // Back-to-back 0x00, 0xFF with one idle cycle between.
    push(8'h00);
    push(8'hFF);
    run_frame(8'h00, -1, -1, -1, '0, w);
    run_frame(8'hFF, -1, -1, -1, '0, w);
    check_eq("b2b_gap_ff", 32'(w), 32'd1);
    check_eq("b2b_pops", 32'(pop_cnt), 32'd3);
    check_eq("b2b_empty", 32'(fifo_empty), 32'd1);

    // Random chain, each next word written into the FIFO mid-frame.
    cur = DW'($urandom);
    push(cur);
    for (int k = 0; k < 6; k++) begin
      nxt = DW'($urandom);
      run_frame(cur, -1, -1, 6 + 5 * k, nxt, w);
      if (k > 0) check_eq("rand_gap", 32'(w), 32'd1);
      cur = nxt;
    end
    run_frame(cur, -1, -1, -1, '0, w);
    check_eq("rand_last_gap", 32'(w), 32'd1);

    // Enable dropped mid-frame; second word must wait for enable.
    cur = DW'($urandom);
    nxt = DW'($urandom);
    push(cur);
    push(nxt);
    run_frame(cur, 5, -1, -1, '0, w);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fifo_read_ins !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
    end
    check_eq("en0_quiet", 32'(viol), 32'd0);
    check_eq("en0_pending", 32'(fifo_empty), 32'd0);
    enable = 1'b1;
    run_frame(nxt, -1, -1, -1, '0, w);

    // Reset during data bit 3 loses the popped word; the next word follows.
    cur = DW'($urandom);
    nxt = DW'($urandom);
    push(cur);
    push(nxt);
    run_frame(cur, -1, (1 + 3) * CPB + 1, -1, '0, w);
    run_frame(nxt, -1, -1, -1, '0, w);
    check_eq("rst_next_empty", 32'(fifo_empty), 32'd1);

    // Empty FIFO throughout.
    viol = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (fifo_read_ins !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
    end
    check_eq("empty_quiet", 32'(viol), 32'd0);

    check_eq("total_pops", 32'(pop_cnt), 32'(wr_ptr));
    check_eq("double_pulse", 32'(dbl_cnt), 32'd0);
    check_eq("pop_on_empty", 32'(empty_pop_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
